// File: rtl/cnn_pkg.sv
// Shared CNN accelerator types and constants.
// Op-code field positions and weight-loader state encoding.
package cnn_pkg;

  localparam int MAX_FILTERS = 32;
  localparam int ELEM_W      = 16;
  localparam int NF_W        = 6;
  localparam int DIM_W       = 5;
  localparam int BEAT_W      = 9;
  localparam int IDX_W       = $clog2(MAX_FILTERS);
  localparam int OP_NF_LSB   = 3;
  localparam int OP_DIM_LSB  = 9;

  typedef enum logic [1:0] {
    WL_IDLE,
    WL_LOAD,
    WL_DONE
  } wl_state_t;

  // Two elements per beat, so a K*K kernel needs ceil(K*K/2) beats.
  function automatic logic [BEAT_W-1:0] beats_per_filter(
    input logic [DIM_W-1:0] k
  );
    logic [9:0]  e;
    logic [10:0] r;
    e = 10'(k) * 10'(k);
    r = (11'(e) + 11'd1) >> 1;
    return BEAT_W'(r);
  endfunction

endpackage

// File: rtl/wl_beat_counter.sv
// Beat / filter index counter pair for the weight loader.
// Holds the filter index on the final filter so it never leaves range.
module wl_beat_counter
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic [BEAT_W-1:0] i_beats,
  input  logic [NF_W-1:0]   i_nf,
  output logic [NF_W-1:0]   o_filt_idx,
  output logic              o_last_beat,
  output logic              o_last_filter
);

  logic [BEAT_W-1:0] r_beat;
  logic [NF_W-1:0]   r_filt;

  assign o_filt_idx    = r_filt;
  assign o_last_beat   = (r_beat == i_beats - BEAT_W'(1));
  assign o_last_filter = (r_filt == i_nf - NF_W'(1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_beat <= '0;
      r_filt <= '0;
    end else if (i_inc) begin
      if (o_last_beat) begin
        r_beat <= '0;
        if (!o_last_filter)
          r_filt <= r_filt + NF_W'(1);
      end else begin
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/weight_load_sched.sv
// Weight load scheduler: streams 2-element beats into per-filter FIFOs.
// One-hot write enable, 1-cycle write latency, odd-E padding lane masked.
module weight_load_sched
  import cnn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [NF_W-1:0]        num_filters_i,
  input  logic [DIM_W-1:0]       weight_dim_i,
  input  logic                   s_valid_i,
  input  logic [2*ELEM_W-1:0]    s_data_i,
  output logic                   s_ready_o,
  input  logic [MAX_FILTERS-1:0] fifo_full_i,
  output logic [MAX_FILTERS-1:0] fifo_wr_en_o,
  output logic [2*ELEM_W-1:0]    fifo_data_o,
  output logic [1:0]             fifo_keep_o,
  output logic [NF_W-1:0]        filt_idx_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   cfg_err_o
);

  wl_state_t         r_state;
  logic [NF_W-1:0]   r_nf;
  logic [BEAT_W-1:0] r_beats;
  logic              r_odd;

  logic [NF_W-1:0]   w_filt_idx;
  logic [IDX_W-1:0]  w_idx;
  logic              w_last_beat;
  logic              w_last_filter;
  logic              w_accept;
  logic              w_cfg_ok;
  logic              w_clr;

  assign w_idx = w_filt_idx[IDX_W-1:0];

  assign w_cfg_ok = (num_filters_i != '0)
                 && (num_filters_i <= NF_W'(MAX_FILTERS))
                 && (weight_dim_i != '0);

  assign w_clr = (r_state == WL_IDLE) && start_i && w_cfg_ok;

  assign s_ready_o = (r_state == WL_LOAD) && !fifo_full_i[w_idx];
  assign w_accept  = s_valid_i && s_ready_o;

  assign filt_idx_o = w_filt_idx;
  assign busy_o     = (r_state == WL_LOAD);
  assign done_o     = (r_state == WL_DONE);

  wl_beat_counter u_cnt (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (w_clr),
    .i_inc         (w_accept),
    .i_beats       (r_beats),
    .i_nf          (r_nf),
    .o_filt_idx    (w_filt_idx),
    .o_last_beat   (w_last_beat),
    .o_last_filter (w_last_filter)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= WL_IDLE;
      r_nf         <= '0;
      r_beats      <= '0;
      r_odd        <= 1'b0;
      fifo_wr_en_o <= '0;
      fifo_data_o  <= '0;
      fifo_keep_o  <= '0;
      cfg_err_o    <= 1'b0;
    end else begin
      fifo_wr_en_o <= '0;
      cfg_err_o    <= 1'b0;
      if (w_accept) begin
        fifo_wr_en_o <= MAX_FILTERS'(1) << w_idx;
        fifo_data_o  <= s_data_i;
        // lane1 of an odd-E final beat is padding
        fifo_keep_o  <= (r_odd && w_last_beat) ? 2'b01 : 2'b11;
      end
      unique case (r_state)
        WL_IDLE: begin
          if (start_i) begin
            if (w_cfg_ok) begin
              r_state <= WL_LOAD;
              r_nf    <= num_filters_i;
              r_beats <= beats_per_filter(weight_dim_i);
              r_odd   <= weight_dim_i[0];
            end else begin
              cfg_err_o <= 1'b1;
            end
          end
        end
        WL_LOAD: begin
          if (w_accept && w_last_beat && w_last_filter)
            r_state <= WL_DONE;
        end
        WL_DONE: r_state <= WL_IDLE;
        default: r_state <= WL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_load_sched.sv
// Directed bench for weight_load_sched.
// Monitor collects writes; tests compare against hand-derived expectations.
module tb_weight_load_sched;
  import cnn_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start_i = 1'b0;
  logic [NF_W-1:0]        num_filters_i = '0;
  logic [DIM_W-1:0]       weight_dim_i = '0;
  logic                   s_valid_i = 1'b0;
  logic [2*ELEM_W-1:0]    s_data_i = '0;
  logic                   s_ready_o;
  logic [MAX_FILTERS-1:0] fifo_full_i = '0;
  logic [MAX_FILTERS-1:0] fifo_wr_en_o;
  logic [2*ELEM_W-1:0]    fifo_data_o;
  logic [1:0]             fifo_keep_o;
  logic [NF_W-1:0]        filt_idx_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   cfg_err_o;

  weight_load_sched dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .num_filters_i (num_filters_i),
    .weight_dim_i  (weight_dim_i),
    .s_valid_i     (s_valid_i),
    .s_data_i      (s_data_i),
    .s_ready_o     (s_ready_o),
    .fifo_full_i   (fifo_full_i),
    .fifo_wr_en_o  (fifo_wr_en_o),
    .fifo_data_o   (fifo_data_o),
    .fifo_keep_o   (fifo_keep_o),
    .filt_idx_o    (filt_idx_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .cfg_err_o     (cfg_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] wr_q[$];
  logic [31:0] dat_q[$];
  logic [1:0]  keep_q[$];
  int          wcyc_q[$];
  int          done_cnt;
  int          done_cyc;
  int          busy_cnt;
  int          cfg_cnt;
  int          both_cnt;
  logic [5:0]  filt_or;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_wr_en_o != '0) begin
      wr_q.push_back(fifo_wr_en_o);
      dat_q.push_back(fifo_data_o);
      keep_q.push_back(fifo_keep_o);
      wcyc_q.push_back(cyc);
    end
    if (done_o) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (busy_o) begin
      busy_cnt <= busy_cnt + 1;
      filt_or  <= filt_or | filt_idx_o;
    end
    if (cfg_err_o) cfg_cnt <= cfg_cnt + 1;
    if (cfg_err_o && done_o) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat(input int n);
    return 32'hC0DE_0000 + 32'(n) * 32'h0001_0003;
  endfunction

  task automatic clear_mon();
    wr_q.delete();
    dat_q.delete();
    keep_q.delete();
    wcyc_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    busy_cnt = 0;
    cfg_cnt  = 0;
    filt_or  = '0;
  endtask

  task automatic start_cfg(input int nf, input int k);
    num_filters_i = NF_W'(nf);
    weight_dim_i  = DIM_W'(k);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input int nb, input bit wait_done,
                     input int st_lo, input int st_hi,
                     input int restart_c);
    int n;
    int c;
    logic acc;
    n = 0;
    c = 0;
    s_valid_i = 1'b1;
    s_data_i = beat(0);
    fifo_full_i = '0;
    while (c < 300 && (n < nb || (wait_done && done_cnt == 0))) begin
      @(negedge clk);
      acc = s_valid_i & s_ready_o;
      if (c >= st_lo && c < st_hi)
        chk("stall_ready", s_ready_o, 0);
      @(posedge clk); #1;
      if (acc) n++;
      if (n >= nb) s_valid_i = 1'b0;
      s_data_i = beat(n);
      c++;
      fifo_full_i = (c >= st_lo && c < st_hi) ? 32'h2 : 32'h0;
      start_i = (c == restart_c);
      if (c == restart_c) num_filters_i = 6'd5;
    end
    s_valid_i = 1'b0;
    fifo_full_i = '0;
    start_i = 1'b0;
    if (c >= 300) chk("timeout", 1, 0);
  endtask

  task automatic verify(input int nb, input int bpf, input bit odd);
    int m;
    chk("wr_count", wr_q.size(), nb);
    m = (wr_q.size() < nb) ? wr_q.size() : nb;
    for (int i = 0; i < m; i++) begin
      chk("wr_en", wr_q[i], 32'(1) << (i / bpf));
      chk("wr_data", dat_q[i], beat(i));
      chk("wr_keep", keep_q[i],
          (odd && (i % bpf) == bpf - 1) ? 2'b01 : 2'b11);
    end
  endtask

  initial begin
    both_cnt = 0;
    clear_mon();
    idle(2);
    @(negedge clk);
    chk("rst_wr_en", fifo_wr_en_o, 0);
    chk("rst_ready", s_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_data", fifo_data_o, 0);
    chk("rst_keep", fifo_keep_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // K=3 NF=2: 5 beats per filter, odd E
    clear_mon();
    start_cfg(2, 3);
    run(10, 1, -1, -1, -1);
    verify(10, 5, 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_at_last_wr", done_cyc,
        (wcyc_q.size() > 0) ? wcyc_q[$] : -1);
    @(negedge clk);
    chk("t1_done_low", done_o, 0);
    chk("t1_busy_low", busy_o, 0);
    @(posedge clk); #1;

    // K=4 NF=1: 8 beats, even E
    clear_mon();
    start_cfg(1, 4);
    run(8, 1, -1, -1, -1);
    idle(2);
    verify(8, 8, 0);
    chk("t2_busy_cycles", busy_cnt, 8);
    chk("t2_filt_idx", filt_or, 0);
    chk("t2_done_cnt", done_cnt, 1);

    // K=3 NF=3 with FIFO 1 full for 4 cycles
    clear_mon();
    start_cfg(3, 3);
    run(15, 1, 7, 11, -1);
    idle(2);
    verify(15, 5, 1);
    chk("t3_done_cnt", done_cnt, 1);

    // invalid configs
    clear_mon();
    start_cfg(0, 3);
    @(negedge clk);
    chk("cfg_nf0", cfg_err_o, 1);
    chk("cfg_nf0_busy", busy_o, 0);
    @(posedge clk); #1;
    start_cfg(33, 3);
    @(negedge clk);
    chk("cfg_nf33", cfg_err_o, 1);
    chk("cfg_nf33_busy", busy_o, 0);
    @(posedge clk); #1;
    start_cfg(2, 0);
    @(negedge clk);
    chk("cfg_k0", cfg_err_o, 1);
    chk("cfg_k0_busy", busy_o, 0);
    @(posedge clk); #1;
    idle(2);
    chk("cfg_pulses", cfg_cnt, 3);
    chk("cfg_no_wr", wr_q.size(), 0);
    chk("cfg_no_busy", busy_cnt, 0);

    // reset after 3 beats of K=5 NF=4
    clear_mon();
    start_cfg(4, 5);
    run(3, 0, -1, -1, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_wr_en", fifo_wr_en_o, 0);
    chk("mrst_data", fifo_data_o, 0);
    chk("mrst_keep", fifo_keep_o, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_filt", filt_idx_o, 0);
    chk("mrst_ready", s_ready_o, 0);
    chk("mrst_done", done_o, 0);
    @(posedge clk); #1;
    clear_mon();
    start_cfg(1, 3);
    run(5, 1, -1, -1, -1);
    idle(2);
    verify(5, 5, 1);

    // restart during LOAD must be ignored
    clear_mon();
    start_cfg(2, 2);
    run(4, 1, -1, -1, 1);
    idle(5);
    verify(4, 2, 0);
    chk("t6_done_cnt", done_cnt, 1);
    chk("done_cfg_overlap", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
